// File: rtl/fpu_issue_if.sv
// fpu_issue_if: bundles the three buses around the FPU issue stage.
//   req_*  : decode -> issue request (op code, two IEEE-single operands, rd tag)
//   fpu_*  : issue -> combinational FPU operands/select, and FPU -> issue result
//   wb_*   : issue -> writeback record
//   busy, state_dbg : status and FSM state for observation
// Modports:
//   master : the issue stage (fpu_issue)
//   slave  : its environment (decode, FPU, writeback)
//
// Handshake rule for both req and wb: a transfer happens on a rising clock
// edge where valid && ready are both 1. The producer may present valid at any
// time. ready may depend combinationally on the consumer-side inputs of the
// same cycle (req_ready follows wb_ready while a record is pending). A record
// presented on wb_* stays frozen until it transfers.
interface fpu_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [4:0]  req_rd;

  logic [31:0] fpu_src1;
  logic [31:0] fpu_src2;
  logic [8:0]  fpu_op;
  logic [31:0] fpu_result;
  logic        fpu_ovf;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ovf;
  logic        wb_is_int;
  logic        wb_illegal;

  logic        busy;
  logic [1:0]  state_dbg;

  modport master (
    input  req_valid, req_op, req_src1, req_src2, req_rd,
    input  fpu_result, fpu_ovf, wb_ready,
    output req_ready, fpu_src1, fpu_src2, fpu_op,
    output wb_valid, wb_rd, wb_data, wb_ovf, wb_is_int, wb_illegal,
    output busy, state_dbg
  );

  modport slave (
    output req_valid, req_op, req_src1, req_src2, req_rd,
    output fpu_result, fpu_ovf, wb_ready,
    input  req_ready, fpu_src1, fpu_src2, fpu_op,
    input  wb_valid, wb_rd, wb_data, wb_ovf, wb_is_int, wb_illegal,
    input  busy, state_dbg
  );
endinterface

// File: rtl/fpu_issue.sv
// fpu_issue: core-side initiator for a combinational FPU datapath.
// Takes one FP op from decode, holds operands and a one-hot select on the FPU
// for a per-class number of cycles (so the FPU can be timed as a multi-cycle
// path), captures result/ovf on the last of those cycles and offers a
// writeback record. flush aborts whatever is in flight.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset (beats flush and handshakes)
//   flush : synchronous abort; suppresses a same-cycle request accept
//   bus   : fpu_issue_if.master (req_*, fpu_*, wb_*, busy, state_dbg)
module fpu_issue #(
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 4,
  parameter int MISC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  fpu_issue_if.master bus
);

  localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_DM  = (DIV_LAT > MISC_LAT) ? DIV_LAT : MISC_LAT;
  localparam int MAX_LAT = (MAX_AM > MAX_DM) ? MAX_AM : MAX_DM;
  localparam int CW      = $clog2(MAX_LAT + 1);

  if (ADD_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1 || MISC_LAT < 1) begin : g_lat_check
    $error("fpu_issue: every latency parameter must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   src1_q, src2_q, wb_data_q;
  logic [4:0]    rd_q;
  logic [3:0]    op_q;
  logic          wb_ovf_q, illegal_q;
  logic          req_ready, accept, req_legal, last_exec;

  function automatic logic [CW-1:0] class_lat(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: class_lat = CW'(ADD_LAT);
      4'd2:       class_lat = CW'(MUL_LAT);
      4'd3:       class_lat = CW'(DIV_LAT);
      default:    class_lat = CW'(MISC_LAT);  // compares/sign-inject; illegal never enters EXEC
    endcase
  endfunction

  assign req_legal = (bus.req_op <= 4'd8);
  assign last_exec = (state == EXEC) && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      WB:      req_ready = bus.wb_ready;  // a new op may enter as the record retires
      default: req_ready = 1'b0;
    endcase
    accept = bus.req_valid && req_ready && !flush;
    case (state)
      IDLE: if (accept) state_nx = req_legal ? EXEC : WB;
      EXEC: if (cnt == CW'(1)) state_nx = WB;
      WB: begin
        if (bus.wb_ready) begin
          if (accept) state_nx = req_legal ? EXEC : WB;
          else        state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Operand/record holding registers. An illegal op lands straight in WB with
  // a zero result, so the capture path is cleared at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      src1_q    <= '0;
      src2_q    <= '0;
      rd_q      <= '0;
      op_q      <= '0;
      cnt       <= '0;
      wb_data_q <= '0;
      wb_ovf_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      src1_q    <= bus.req_src1;
      src2_q    <= bus.req_src2;
      rd_q      <= bus.req_rd;
      op_q      <= bus.req_op;
      cnt       <= class_lat(bus.req_op);
      wb_data_q <= '0;
      wb_ovf_q  <= 1'b0;
      illegal_q <= !req_legal;
    end else if (state == EXEC) begin
      cnt <= cnt - CW'(1);
      if (last_exec) begin
        wb_data_q <= bus.fpu_result;
        wb_ovf_q  <= bus.fpu_ovf;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.fpu_src1   = src1_q;
  assign bus.fpu_src2   = src2_q;
  assign bus.fpu_op     = (state == EXEC) ? (9'b1 << op_q) : 9'b0;
  // Record fields read as zero whenever no record is offered.
  assign bus.wb_valid   = (state == WB);
  assign bus.wb_rd      = (state == WB) ? rd_q : 5'd0;
  assign bus.wb_data    = (state == WB) ? wb_data_q : 32'd0;
  assign bus.wb_ovf     = (state == WB) && wb_ovf_q;
  assign bus.wb_is_int  = (state == WB) && (op_q >= 4'd6) && (op_q <= 4'd8);
  assign bus.wb_illegal = (state == WB) && illegal_q;
  assign bus.busy       = (state != IDLE);
  assign bus.state_dbg  = state;

endmodule
